// File: rtl/mult3_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mult3_pkg
//  Description : Shared widths, latency, tag type and FSM encoding for the
//                3-bit multiplier scheduler slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult3_pkg;

  localparam int MULT3_W       = 3;  // operand width
  localparam int MULT3_PW      = 6;  // product width (7*7=49 fits)
  localparam int MULT3_LAT     = 2;  // input FF + output FF
  localparam int MULT3_IDW_MAX = 3;  // enough id bits for up to 8 requesters

  // Scheduler FSM encoding
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  // One in-flight operation: valid flag plus issuing requester id
  typedef struct packed {
    logic                     vld;
    logic [MULT3_IDW_MAX-1:0] id;
  } tag_t;

  // Modulo-n increment used for the round-robin pointer
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult3_rr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first active
//                request at or after ptr, searching modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  // Requests duplicated so a rotation by ptr is a plain part-select
  logic [2*NUM_REQ-2:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDW:0]         off;
  logic [IDW:0]         sum;
  logic                 unused_sum_msb;

  // Rotate, find the lowest active offset, translate back to an absolute id
  always_comb begin
    req_dbl = {req[NUM_REQ-2:0], req};
    req_rot = req_dbl[{1'b0, ptr} +: NUM_REQ];
    off     = '0;
    any     = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = (IDW+1)'(k);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDW+1)'(NUM_REQ)) begin
      sum = sum - (IDW+1)'(NUM_REQ);
    end
    gnt_id = sum[IDW-1:0];
    gnt    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = any && (gnt_id == IDW'(i));
    end
  end

  // After the modulo correction the top bit is always zero
  assign unused_sum_msb = sum[IDW];

endmodule
`default_nettype wire

// File: rtl/parallel_3_bit_mult.sv
`default_nettype none
// ============================================================================
//  Module      : parallel_3_bit_mult
//  Description : 3x3 unsigned multiplier with registered inputs and output.
//                Operands captured at edge t appear on o_p in cycle t+2.
//  Revision    : 1.0 - initial release
// ============================================================================
module parallel_3_bit_mult
  import mult3_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [MULT3_W-1:0]  i_a,
  input  logic [MULT3_W-1:0]  i_b,
  output logic [MULT3_PW-1:0] o_p
);

  logic [MULT3_W-1:0]  a_q, a_d;
  logic [MULT3_W-1:0]  b_q, b_d;
  logic [MULT3_PW-1:0] p_q, p_d;

  // Next-state: capture operands, multiply the captured pair
  always_comb begin
    a_d = i_a;
    b_d = i_b;
    p_d = {3'b000, a_q} * {3'b000, b_q};
  end

  // Two register stages, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign o_p = p_q;

endmodule
`default_nettype wire

// File: rtl/mult3_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mult3_rr_scheduler
//  Description : Shares one pipelined 3-bit multiplier between NUM_REQ
//                requesters. Round-robin issue, tag pipe returning the
//                requester id with each product, and a drain FSM that
//                quiesces the multiplier on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult3_rr_scheduler
  import mult3_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = MULT3_LAT,
  parameter int IDW      = $clog2(NUM_REQ)
) (
  input  logic                   CLK1,
  input  logic                   RST1,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_a,
  input  logic [3*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [MULT3_W-1:0]     mul_a,
  output logic [MULT3_W-1:0]     mul_b,
  input  logic [MULT3_PW-1:0]    mul_p,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [MULT3_PW-1:0]    rsp_p,
  input  logic                   drain_req,
  output logic                   drained,
  output logic [1:0]             inflight
);

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_gnt_id;
  logic               arb_any;
  logic               grant_en;
  logic               xfer;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [1:0]         state_q, state_d;
  tag_t               tag_q [MULT_LAT];
  tag_t               tag_d [MULT_LAT];
  logic [1:0]         inflight_cnt;
  logic               unused_last_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_gnt_id),
    .any    (arb_any)
  );

  // Grant gating and operand mux; reset also masks grants so nothing leaks
  // out while the pipeline is being cleared
  always_comb begin
    grant_en  = (state_q == ST_RUN) && !drain_req && !RST1;
    xfer      = arb_any && grant_en;
    req_ready = grant_en ? arb_gnt : '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_a = req_a[3*i +: 3];
        mul_b = req_b[3*i +: 3];
      end
    end
  end

  // Pointer moves past the winner only when an operation is actually taken
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = IDW'(wrap_inc(int'(arb_gnt_id), NUM_REQ));
    end
  end

  // Tag pipe mirrors the multiplier latency; shifts every cycle, never stalls
  always_comb begin
    tag_d[0].vld = xfer;
    tag_d[0].id  = MULT3_IDW_MAX'(arb_gnt_id);
    for (int s = 1; s < MULT_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Operations in flight = number of valid tags in the pipe
  always_comb begin
    inflight_cnt = '0;
    for (int s = 0; s < MULT_LAT; s++) begin
      inflight_cnt = inflight_cnt + {1'b0, tag_q[s].vld};
    end
  end

  // Drain FSM: stop issuing, wait for the pipe to empty, hold until released
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)             state_d = ST_RUN;
        else if (inflight_cnt == 0) state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers; async reset discards any tags still in flight
  always_ff @(posedge CLK1 or posedge RST1) begin
    if (RST1) begin
      ptr_q   <= '0;
      state_q <= ST_RUN;
      for (int s = 0; s < MULT_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      state_q <= state_d;
      for (int s = 0; s < MULT_LAT; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign rsp_valid      = tag_q[MULT_LAT-1].vld;
  assign rsp_id         = tag_q[MULT_LAT-1].id[IDW-1:0];
  assign rsp_p          = mul_p;
  assign drained        = (state_q == ST_DRAINED);
  assign inflight       = inflight_cnt;
  // Upper id bits are only present to size the shared tag type
  assign unused_last_id = ^tag_q[MULT_LAT-1].id;

endmodule
`default_nettype wire

// File: tb/tb_mult3_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult3_rr_scheduler
//  Description : Self-checking bench for mult3_rr_scheduler with the shared
//                multiplier attached. Reference model tracks a pointer, a
//                mode and a queue of pending results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult3_rr_scheduler;

  logic        CLK1;
  logic        RST1;
  logic [3:0]  req_valid;
  logic [11:0] req_a;
  logic [11:0] req_b;
  logic [3:0]  req_ready;
  logic [2:0]  mul_a;
  logic [2:0]  mul_b;
  logic [5:0]  mul_p;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_p;
  logic        drain_req;
  logic        drained;
  logic [1:0]  inflight;

  logic [2:0]  op_a [4];
  logic [2:0]  op_b [4];

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  mult3_rr_scheduler #(.NUM_REQ(4), .MULT_LAT(2), .IDW(2)) dut (
    .CLK1(CLK1), .RST1(RST1), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .drain_req(drain_req), .drained(drained), .inflight(inflight)
  );

  parallel_3_bit_mult u_mult (
    .clk(CLK1), .rst(RST1), .i_a(mul_a), .i_b(mul_b), .o_p(mul_p)
  );

  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  typedef struct { int due; int id; int p; } rsp_t;
  rsp_t m_q[$];
  int   m_ptr;
  int   m_mode;   // 0 = issuing, 1 = draining, 2 = drained

  int          e_gid;
  logic        e_rv;
  int          e_infl;
  logic [21:0] exp_vec;

  function automatic logic [21:0] obs_vec();
    return {req_ready, mul_a, mul_b, rsp_valid,
            rsp_valid ? rsp_id : 2'b00, rsp_valid ? rsp_p : 6'd0,
            drained, inflight};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ptr  = 0;
    m_mode = 0;
    cyc    = 0;
  endtask

  // Expected outputs for the current cycle from the current inputs
  task automatic model_eval();
    logic [3:0] rdy;
    logic [2:0] ea, eb;
    logic [1:0] eid;
    logic [5:0] ep;
    e_gid = -1;
    if (m_mode == 0 && !drain_req) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (req_valid[j] && e_gid < 0) e_gid = j;
      end
    end
    rdy = 4'b0000; ea = 3'd0; eb = 3'd0;
    if (e_gid >= 0) begin
      rdy[e_gid] = 1'b1;
      ea = op_a[e_gid];
      eb = op_b[e_gid];
    end
    e_rv = (m_q.size() > 0) && (m_q[0].due == cyc);
    eid = 2'd0; ep = 6'd0;
    if (e_rv) begin
      eid = 2'(m_q[0].id);
      ep  = 6'(m_q[0].p);
    end
    e_infl  = m_q.size();
    exp_vec = {rdy, ea, eb, e_rv, eid, ep, (m_mode == 2), 2'(e_infl)};
  endtask

  // Apply this cycle's transfer, retirement and mode change
  task automatic model_advance();
    if (e_rv) void'(m_q.pop_front());
    if (e_gid >= 0) begin
      rsp_t r;
      r.due = cyc + 2;
      r.id  = e_gid;
      r.p   = int'(op_a[e_gid]) * int'(op_b[e_gid]);
      m_q.push_back(r);
      m_ptr = (e_gid + 1) % 4;
    end
    case (m_mode)
      0: if (drain_req) m_mode = 1;
      1: if (!drain_req) m_mode = 0; else if (e_infl == 0) m_mode = 2;
      default: if (!drain_req) m_mode = 0;
    endcase
    cyc++;
  endtask

  // Inputs are changed at the falling edge, outputs sampled 1 time unit later
  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge CLK1);
    model_advance();
    @(negedge CLK1);
  endtask

  task automatic clear_inputs();
    req_valid = 4'b0000;
    drain_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 3'd0;
      op_b[i] = 3'd0;
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    RST1 = 1'b1;
    @(posedge CLK1);
    @(negedge CLK1);
    RST1 = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    settle();
    checks++;
    if (obs_vec() !== 22'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 22'd0);
    end
    checks++;
    if (obs_vec() !== exp_vec) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec);
    end
    advance();
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0001; op_a[0] = 3'd5; op_b[0] = 3'd7;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant got=%b exp=%b", req_ready, 4'b0001);
    end
    checks++;
    if (obs_vec() !== exp_vec) begin
      failures++;
      $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
    end
    advance();
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      if (i == 1) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 2'd0, 6'd35}) begin
          failures++;
          $display("FAIL single_rsp got=%b/%0d/%0d exp=1/0/35", rsp_valid, rsp_id, rsp_p);
        end
      end
      advance();
    end
  endtask

  task automatic test_all_four();
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 3'(i + 1);
      op_b[i] = 3'd7;
    end
    for (int k = 0; k < 12; k++) begin
      logic [3:0] eg;
      settle();
      eg = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== eg) begin
        failures++;
        $display("FAIL rr_order k=%0d got=%b exp=%b", k, req_ready, eg);
      end
      if (k >= 2) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 2'((k - 2) % 4), 6'(7 * ((k - 2) % 4 + 1))}) begin
          failures++;
          $display("FAIL rr_rsp k=%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, rsp_valid, rsp_id,
                   rsp_p, (k - 2) % 4, 7 * ((k - 2) % 4 + 1));
        end
      end
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_ptr_skip();
    logic [3:0] eg [3];
    logic [3:0] rv [3];
    apply_reset();
    rv[0] = 4'b0010; eg[0] = 4'b0010;   // moves pointer to 2
    rv[1] = 4'b1010; eg[1] = 4'b1000;   // search from 2 finds 3
    rv[2] = 4'b1010; eg[2] = 4'b0010;   // wraps to 0, finds 1
    for (int k = 0; k < 3; k++) begin
      req_valid = rv[k];
      op_a[1] = 3'(k + 2); op_b[1] = 3'd3;
      op_a[3] = 3'd6;      op_b[3] = 3'(k + 1);
      settle();
      checks++;
      if (req_ready !== eg[k]) begin
        failures++;
        $display("FAIL ptr_skip k=%0d got=%b exp=%b", k, req_ready, eg[k]);
      end
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL ptr_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL ptr_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_drain();
    int rsp_cnt;
    int first_drained;
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 3'($urandom_range(0, 7));
      op_b[i] = 3'($urandom_range(0, 7));
    end
    for (int k = 0; k < 10; k++) begin
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL drain_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
    drain_req     = 1'b1;
    rsp_cnt       = 0;
    first_drained = -1;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL drain_nogrant rel=%0d got=%b exp=0000", k, req_ready);
      end
      checks++;
      if (rsp_valid === 1'b1) rsp_cnt++;
      if (drained === 1'b1 && first_drained < 0) first_drained = k;
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL drain_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
    checks++;
    if (rsp_cnt !== 2) begin
      failures++;
      $display("FAIL drain_rsp_count got=%0d exp=2", rsp_cnt);
    end
    checks++;
    if (first_drained !== 3) begin
      failures++;
      $display("FAIL drain_latency got=%0d exp=3", first_drained);
    end
    drain_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (k == 1) begin
        checks++;
        if (req_ready === 4'b0000) begin
          failures++;
          $display("FAIL drain_resume got=%b exp=nonzero", req_ready);
        end
      end
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL drain_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int rsp_cnt;
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 3'(i + 2);
      op_b[i] = 3'd5;
    end
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
    #1 RST1 = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, drained, inflight, mul_a, mul_b} !== 15'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%b/%0d/%b/%0d/%0d/%0d exp=all zero",
               req_ready, rsp_valid, rsp_id, drained, inflight, mul_a, mul_b);
    end
    #1 RST1 = 1'b0;
    model_reset();
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_first_grant got=%b exp=%b", req_ready, 4'b0001);
    end
    advance();
    req_valid = 4'b0000;
    rsp_cnt   = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (rsp_valid === 1'b1) rsp_cnt++;
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
    checks++;
    if (rsp_cnt !== 1) begin
      failures++;
      $display("FAIL rstmid_stale_rsp got=%0d exp=1", rsp_cnt);
    end
  endtask

  task automatic test_corners();
    apply_reset();
    req_valid = 4'b0100;
    op_a[2] = 3'd7; op_b[2] = 3'd7;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        op_a[2] = 3'd0; op_b[2] = 3'd6;
      end
      if (k == 2) req_valid = 4'b0000;
      settle();
      if (k == 2) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 2'd2, 6'd49}) begin
          failures++;
          $display("FAIL corner_max got=%b/%0d/%0d exp=1/2/49", rsp_valid, rsp_id, rsp_p);
        end
      end
      if (k == 3) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 2'd2, 6'd0}) begin
          failures++;
          $display("FAIL corner_zero got=%b/%0d/%0d exp=1/2/0", rsp_valid, rsp_id, rsp_p);
        end
      end
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL corner_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        op_a[i] = 3'($urandom);
        op_b[i] = 3'($urandom);
      end
      if ($urandom_range(0, 11) == 0) drain_req = ~drain_req;
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    RST1 = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge CLK1);
    test_reset();
    test_single();
    test_all_four();
    test_ptr_skip();
    test_drain();
    test_reset_mid();
    test_corners();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
